// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/issue sequencer with a 5-bit PC, nop/halt handling
// and a conditional branch on gz_flag (opcode 3'b011).
// Optional feature macro: ISEQ_RETIRE_CNT_EN adds an 8-bit saturating
// retired_cnt output that counts accepted issues (nop and halt are never issued).
module instr_sequencer (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [4:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [2:0] opcode,
  output logic [4:0] operand,
  output logic       issue_valid,
  input  logic       issue_ready,
  input  logic       gz_flag,
  output logic       halted
`ifdef ISEQ_RETIRE_CNT_EN
  ,
  output logic [7:0] retired_cnt
`endif
);

  localparam int unsigned PC_W  = 5;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned INS_W = 8;

  localparam logic [OP_W-1:0] OP_GZ   = 3'b011;
  localparam logic [OP_W-1:0] OP_NOP  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [INS_W-1:0]  ir;

  assign imem_addr = pc;

  // Sequencer FSM: fetch, issue, PC update; all outputs registered.
  // In FETCH, imem_req low marks the one-cycle bubble after a nop; ack is ignored then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      imem_req    <= 1'b0;
      issue_valid <= 1'b0;
      halted      <= 1'b0;
      opcode      <= '0;
      operand     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            case (imem_data[7:5])
              OP_NOP:  pc <= pc + PC_W'(1);
              OP_HALT: begin
                state  <= S_HALT;
                halted <= 1'b1;
              end
              default: begin
                state       <= S_ISSUE;
                issue_valid <= 1'b1;
                opcode      <= imem_data[7:5];
                operand     <= imem_data[4:0];
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            state       <= S_FETCH;
            imem_req    <= 1'b1;
            issue_valid <= 1'b0;
            opcode      <= '0;
            operand     <= '0;
            if (ir[7:5] == OP_GZ && gz_flag) pc <= ir[4:0];
            else                             pc <= pc + PC_W'(1);
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ISEQ_RETIRE_CNT_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating count of accepted issues.
  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_cnt <= '0;
    end else if (state == S_ISSUE && issue_ready && retired_cnt != CNT_MAX) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       imem_req;
  logic [4:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic       gz_flag = 1'b0;
  logic       halted;
`ifdef ISEQ_RETIRE_CNT_EN
  logic [7:0] retired_cnt;
`endif

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .opcode      (opcode),
    .operand     (operand),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .gz_flag     (gz_flag),
    .halted      (halted)
`ifdef ISEQ_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mem [32];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for the next rising edge, then return just after that edge.
  task automatic step(input bit rst, input bit ack, input bit rdy, input bit gz);
    @(negedge clk);
    #1;
    reset       = rst;
    imem_ack    = ack;
    issue_ready = rdy;
    gz_flag     = gz;
    imem_data   = ack ? mem[imem_addr] : 8'($urandom);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] rand_instr();
    logic [7:0] v;
    v = 8'($urandom);
    if (v[7:5] == 3'b111 && $urandom_range(0, 7) != 0) v[7:5] = 3'b000;
    return v;
  endfunction

  // Behavioural model: expected outputs after each edge, derived from the
  // inputs that edge consumed (inputs do not change until after the falling edge).
  int  m_pc = 0, m_cnt = 0, m_op = 0, m_opd = 0;
  bit  m_req = 0, m_valid = 0, m_halted = 0, m_idle = 0, m_bubble = 0;

  initial begin
    logic [7:0] ins;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_pc = 0; m_req = 0; m_valid = 0; m_op = 0; m_opd = 0;
        m_halted = 0; m_idle = 1; m_bubble = 0; m_cnt = 0;
      end else if (m_idle) begin
        m_idle = 0; m_req = 1;
      end else if (m_halted) begin
        m_req = 0;
      end else if (m_valid) begin
        if (issue_ready) begin
          m_pc    = (m_op == 3 && gz_flag) ? m_opd : (m_pc + 1) % 32;
          m_valid = 0; m_op = 0; m_opd = 0; m_req = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (m_bubble) begin
        m_bubble = 0; m_req = 1;
      end else if (m_req && imem_ack) begin
        ins   = imem_data;
        m_req = 0;
        if (ins[7:5] == 3'b110) begin
          m_pc = (m_pc + 1) % 32; m_bubble = 1;
        end else if (ins[7:5] == 3'b111) begin
          m_halted = 1;
        end else begin
          m_valid = 1; m_op = int'(ins[7:5]); m_opd = int'(ins[4:0]);
        end
      end
      chk("model_imem_req", imem_req, m_req);
      chk("model_imem_addr", imem_addr, m_pc);
      chk("model_issue_valid", issue_valid, m_valid);
      chk("model_opcode", opcode, m_op);
      chk("model_operand", operand, m_opd);
      chk("model_halted", halted, m_halted);
`ifdef ISEQ_RETIRE_CNT_EN
      chk("model_retired_cnt", retired_cnt, m_cnt);
`endif
    end
  end

  initial begin
    int hold;
    for (int i = 0; i < 32; i++) mem[i] = 8'h01;
    mem[0] = 8'h05; mem[1] = 8'h02; mem[2] = 8'hC0; mem[3] = 8'h6A;
    mem[10] = 8'h6A; mem[11] = 8'h7F; mem[31] = 8'h20;

    // reset state
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", issue_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_opcode", opcode, 0);

    // first fetch/issue of 8'h05
    step(1, 0, 1, 0);
    chk("idle_to_fetch_req", imem_req, 1);
    step(1, 1, 1, 0);
    chk("addo_valid", issue_valid, 1);
    chk("addo_opcode", opcode, 0);
    chk("addo_operand", operand, 5);
    step(1, 0, 1, 0);
    chk("addo_done_valid", issue_valid, 0);
    chk("addo_next_addr", imem_addr, 1);

    // nop bubble, then branch at PC=3 with a 4-cycle stall
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    chk("nop_req_drop", imem_req, 0);
    chk("nop_addr", imem_addr, 3);
    chk("nop_not_issued", issue_valid, 0);
    step(1, 1, 1, 0);
    chk("nop_req_back", imem_req, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 1);
      chk("stall_opcode", opcode, 3);
      chk("stall_operand", operand, 10);
      chk("stall_addr", imem_addr, 3);
    end
    step(1, 0, 1, 1);
    chk("gz_taken_addr", imem_addr, 10);
    step(1, 1, 1, 0);
    step(1, 0, 1, 1);
    chk("self_loop_addr", imem_addr, 10);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    chk("gz_not_taken_addr", imem_addr, 11);

    // reach PC=31, wrap to 0, then halt
    step(1, 1, 1, 0);
    step(1, 0, 1, 1);
    chk("to_pc31_addr", imem_addr, 31);
    mem[0] = 8'hE0;
    step(1, 1, 1, 0);
    chk("subo_opcode", opcode, 1);
    step(1, 0, 1, 0);
    chk("wrap_addr", imem_addr, 0);
    step(1, 1, 1, 0);
    chk("halt_halted", halted, 1);
    chk("halt_not_issued", issue_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 1);
      chk("halt_req_low", imem_req, 0);
      chk("halt_stays", halted, 1);
    end
    step(0, 0, 0, 0);
    chk("halt_reset_halted", halted, 0);
    chk("halt_reset_addr", imem_addr, 0);

    // reset while a fetch is pending
    mem[0] = 8'h05;
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("pending_req", imem_req, 1);
    chk("pending_addr", imem_addr, 1);
    step(0, 1, 1, 0);
    chk("abort_req", imem_req, 0);
    chk("abort_addr", imem_addr, 0);
    chk("abort_valid", issue_valid, 0);

    // 300 accepted instructions
    for (int i = 0; i < 32; i++) mem[i] = 8'h01;
    step(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 1, 0);
      step(1, 0, 1, 0);
    end
    chk("after300_addr", imem_addr, 12);
`ifdef ISEQ_RETIRE_CNT_EN
    chk("retired_sat", retired_cnt, 255);
`endif

    // randomized traffic
    for (int i = 0; i < 32; i++) mem[i] = rand_instr();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      bit rst;
      hold = halted ? hold + 1 : 0;
      rst  = !(hold > 6 || $urandom_range(0, 299) == 0);
      if (!rst) begin
        hold = 0;
        for (int i = 0; i < 32; i++) mem[i] = rand_instr();
      end
      step(rst, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
